// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit
// Purpose  : Byte/halfword/word load-store sequencer in front of a word-wide
//            RAM with one-cycle registered read. Sub-word stores are done as
//            read-modify-write; loads return a sign/zero-extended result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module mem_access_unit #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_misaligned,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [31:0]           ram_write_data,
  input  logic [31:0]           ram_data
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ      = 3'd1;
  localparam logic [2:0] S_LOAD_DATA = 3'd2;
  localparam logic [2:0] S_MERGE     = 3'd3;
  localparam logic [2:0] S_WRITE     = 3'd4;
  localparam logic [2:0] S_RESP      = 3'd5;

  logic [2:0]  state;

  // Latched request fields. The aligned word address lives in ram_address,
  // so only the lane bits of the address are kept here.
  logic        lat_we;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_lane;
  logic [15:0] lat_wdata;

  logic        misaligned;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_value;
  logic [31:0] merged;

  assign misaligned = (req_size == 2'b11) ||
                      ((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  // Handshake and RAM write strobe are pure state decodes.
  assign req_ready  = (state == S_IDLE);
  assign resp_valid = (state == S_RESP);
  assign ram_wren   = (state == S_WRITE);

  // Lane extraction and extension of the word returned by the RAM.
  always_comb begin
    ld_byte    = 8'h00;
    ld_half    = 16'h0000;
    load_value = ram_data;
    case (lat_lane)
      2'd0:    ld_byte = ram_data[7:0];
      2'd1:    ld_byte = ram_data[15:8];
      2'd2:    ld_byte = ram_data[23:16];
      default: ld_byte = ram_data[31:24];
    endcase
    ld_half = lat_lane[1] ? ram_data[31:16] : ram_data[15:0];
    case (lat_size)
      2'b00:   load_value = lat_unsigned ? {24'h000000, ld_byte}
                                         : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   load_value = lat_unsigned ? {16'h0000, ld_half}
                                         : {{16{ld_half[15]}}, ld_half};
      default: load_value = ram_data;
    endcase
  end

  // Read-modify-write merge: replace only the addressed lane.
  always_comb begin
    merged = ram_data;
    if (lat_size == 2'b00) begin
      case (lat_lane)
        2'd0:    merged[7:0]   = lat_wdata[7:0];
        2'd1:    merged[15:8]  = lat_wdata[7:0];
        2'd2:    merged[23:16] = lat_wdata[7:0];
        default: merged[31:24] = lat_wdata[7:0];
      endcase
    end else if (lat_lane[1]) begin
      merged[31:16] = lat_wdata;
    end else begin
      merged[15:0] = lat_wdata;
    end
  end

  // Sequencer: request latch, state transitions and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      lat_we          <= 1'b0;
      lat_size        <= 2'b00;
      lat_unsigned    <= 1'b0;
      lat_lane        <= 2'b00;
      lat_wdata       <= 16'h0000;
      resp_rdata      <= 32'h0;
      resp_misaligned <= 1'b0;
      ram_address     <= '0;
      ram_write_data  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_lane     <= req_addr[1:0];
            lat_wdata    <= req_wdata[15:0];
            // Stores and faults report zero data, so clear any old load result.
            resp_rdata   <= 32'h0;
            if (misaligned) begin
              resp_misaligned <= 1'b1;
              state           <= S_RESP;
            end else begin
              ram_address <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              if (req_we && (req_size == 2'b10)) begin
                ram_write_data <= req_wdata;
                state          <= S_WRITE;
              end else begin
                state <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          state <= lat_we ? S_MERGE : S_LOAD_DATA;
        end
        S_LOAD_DATA: begin
          resp_rdata <= load_value;
          state      <= S_RESP;
        end
        S_MERGE: begin
          ram_write_data <= merged;
          state          <= S_WRITE;
        end
        S_WRITE: begin
          state <= S_RESP;
        end
        S_RESP: begin
          resp_misaligned <= 1'b0;
          state           <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit with a registered-read
//            RAM model and a transaction-level reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_access_unit;

  localparam int AW     = 17;
  localparam int NWORDS = 1 << (AW - 2);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = 32'h0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_misaligned;
  logic          ram_wren;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_write_data;
  logic [31:0]   ram_data;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .ram_wren        (ram_wren),
    .ram_address     (ram_address),
    .ram_write_data  (ram_write_data),
    .ram_data        (ram_data)
  );

  // RAM driven by the DUT and the golden copy kept by the model
  logic [31:0] mem  [0:NWORDS-1];
  logic [31:0] gold [0:NWORDS-1];

  initial for (int i = 0; i < NWORDS; i++) mem[i]  = 32'(i) * 32'h9E3779B9;
  initial for (int i = 0; i < NWORDS; i++) gold[i] = 32'(i) * 32'h9E3779B9;

  // Word RAM with one-cycle registered read
  always @(posedge clk) begin
    if (ram_wren) mem[ram_address[AW-1:2]] <= ram_write_data;
    ram_data <= mem[ram_address[AW-1:2]];
  end

  // Counters and model state
  int total = 0;
  int bad   = 0;
  int acc_cnt = 0;
  int k = 0;
  logic busy = 1'b0, idle = 1'b0, armed = 1'b0, rst_edge = 1'b0;
  logic m_we, m_un, m_fault;
  logic [1:0] m_sz;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wd, m_rdata;
  int m_lat, m_wk;
  logic write_now = 1'b0;
  int w_idx;
  logic [31:0] w_val;
  logic e_resp, e_wren;
  int sweep_ack = 0;
  int nd;

  // Literal expectations set by the directed tests
  logic lit_en = 1'b0, lit_mis = 1'b0, lit_wchk = 1'b0, lit_mchk = 1'b0;
  logic [31:0] lit_rdata = 0, lit_wdata = 0, lit_mval = 0;
  int lit_lat = 0;
  logic [AW-1:0] lit_maddr = '0;
  int sweep_req = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lane_shift(input logic [1:0] sz, input logic [AW-1:0] a);
    return (sz == 2'b00) ? 8 * int'(a[1:0]) : 16 * int'(a[1]);
  endfunction

  function automatic logic [31:0] lane_base(input logic [1:0] sz);
    return (sz == 2'b00) ? 32'h000000FF : 32'h0000FFFF;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic un, input logic [AW-1:0] a);
    logic [31:0] v, base;
    if (sz == 2'b10) return w;
    base = lane_base(sz);
    v = (w >> lane_shift(sz, a)) & base;
    if (!un && ((v & ((base >> 1) + 32'd1)) != 0)) v = v | ~base;
    return v;
  endfunction

  function automatic logic [31:0] new_word(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [AW-1:0] a, input logic [31:0] wd);
    logic [31:0] mask;
    if (sz == 2'b10) return wd;
    mask = lane_base(sz) << lane_shift(sz, a);
    return (w & ~mask) | ((wd << lane_shift(sz, a)) & mask);
  endfunction

  // Reference model: acceptance/RAM update on the rising edge, output
  // comparison on the falling edge.
  always @(clk) begin
    if (clk) begin
      if (write_now) begin
        gold[w_idx] = w_val;
        write_now = 1'b0;
      end
      rst_edge = rst;
      if (rst) begin
        armed = 1'b1;
        busy  = 1'b0;
        idle  = 1'b0;
      end else if (armed && idle && !busy && req_valid) begin
        m_we    = req_we;
        m_sz    = req_size;
        m_un    = req_unsigned;
        m_addr  = req_addr;
        m_wd    = req_wdata;
        m_fault = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
        m_lat   = m_fault ? 0 : (!m_we ? 2 : (m_sz == 2'b10 ? 1 : 3));
        m_wk    = (m_sz == 2'b10) ? 0 : 2;
        m_rdata = load_val(gold[int'(m_addr[AW-1:2])], m_sz, m_un, m_addr);
        busy    = 1'b1;
        k       = 0;
        acc_cnt++;
      end
    end else if (armed) begin
      if (rst_edge) begin
        chk("reset_resp_rdata", resp_rdata, 32'h0);
        chk("reset_ram_address", 32'(ram_address), 32'h0);
        chk("reset_ram_write_data", ram_write_data, 32'h0);
      end
      e_resp = busy && (k == m_lat);
      e_wren = busy && m_we && !m_fault && (k == m_wk);
      chk("req_ready", 32'(req_ready), 32'(!busy));
      chk("resp_valid", 32'(resp_valid), 32'(e_resp));
      chk("ram_wren", 32'(ram_wren), 32'(e_wren));
      chk("resp_misaligned", 32'(resp_misaligned), 32'(e_resp && m_fault));
      if (e_resp) chk("resp_rdata", resp_rdata, (m_we || m_fault) ? 32'h0 : m_rdata);
      if (e_wren) begin
        w_idx = int'(m_addr[AW-1:2]);
        w_val = new_word(gold[w_idx], m_sz, m_addr, m_wd);
        write_now = 1'b1;
        chk("ram_address", 32'(ram_address), 32'({m_addr[AW-1:2], 2'b00}));
        chk("ram_write_data", ram_write_data, w_val);
      end
      if (lit_en && e_resp) begin
        chk("lit_rdata", resp_rdata, lit_rdata);
        chk("lit_misaligned", 32'(resp_misaligned), 32'(lit_mis));
      end
      if (lit_en && busy && resp_valid) chk("lit_latency", 32'(k), 32'(lit_lat));
      if (lit_en && lit_wchk && ram_wren) chk("lit_write_data", ram_write_data, lit_wdata);
      if (sweep_req != sweep_ack) begin
        sweep_ack = sweep_req;
        nd = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== gold[i]) nd++;
        for (int i = NWORDS - 8; i < NWORDS; i++) if (mem[i] !== gold[i]) nd++;
        chk("mem_diff_words", 32'(nd), 32'h0);
        if (lit_mchk) chk("lit_mem", mem[int'(lit_maddr[AW-1:2])], lit_mval);
      end
      idle = !busy;
      if (busy) begin
        if (k == m_lat) busy = 1'b0;
        else k++;
      end
    end
  end

  // Stimulus helpers
  task automatic issue(input logic we, input logic [1:0] sz, input logic un,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    int n, t;
    n = acc_cnt;
    t = 0;
    req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    while (acc_cnt == n && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = AW'($urandom); req_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || !idle) && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
  endtask

  task automatic lit_req(input logic we, input logic [1:0] sz, input logic un,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [31:0] ex_rd, input logic ex_mis, input int ex_lat,
                         input logic wchk, input logic [31:0] ex_wd);
    lit_rdata = ex_rd; lit_mis = ex_mis; lit_lat = ex_lat;
    lit_wchk = wchk; lit_wdata = ex_wd;
    lit_en = 1'b1;
    issue(we, sz, un, a, wd);
    wait_idle();
    lit_en = 1'b0;
  endtask

  task automatic sweep(input logic mchk, input logic [AW-1:0] a, input logic [31:0] v);
    lit_mchk = mchk; lit_maddr = a; lit_mval = v;
    sweep_req++;
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0] sz;
    logic [AW-1:0] a;
    int r;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    wait_idle();

    // Word store then load
    lit_req(1, 2'b10, 0, 'h100, 32'hDEADBEEF, 32'h0, 0, 1, 1, 32'hDEADBEEF);
    lit_req(0, 2'b10, 0, 'h100, 32'h0, 32'hDEADBEEF, 0, 2, 0, 32'h0);

    // Byte loads
    lit_req(1, 2'b10, 0, 'h20, 32'h80FF7F01, 32'h0, 0, 1, 1, 32'h80FF7F01);
    lit_req(0, 2'b00, 0, 'h23, 32'h0, 32'hFFFFFF80, 0, 2, 0, 32'h0);
    lit_req(0, 2'b00, 1, 'h23, 32'h0, 32'h00000080, 0, 2, 0, 32'h0);
    lit_req(0, 2'b00, 0, 'h21, 32'h0, 32'h0000007F, 0, 2, 0, 32'h0);

    // Halfword read-modify-write and extension
    lit_req(1, 2'b10, 0, 'h40, 32'h11223344, 32'h0, 0, 1, 1, 32'h11223344);
    lit_req(1, 2'b01, 0, 'h42, 32'h1234ABCD, 32'h0, 0, 3, 1, 32'hABCD3344);
    lit_req(0, 2'b01, 0, 'h42, 32'h0, 32'hFFFFABCD, 0, 2, 0, 32'h0);
    lit_req(0, 2'b01, 1, 'h42, 32'h0, 32'h0000ABCD, 0, 2, 0, 32'h0);

    // Faults
    lit_req(0, 2'b10, 0, 'h102, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    lit_req(0, 2'b01, 0, 'h101, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    lit_req(0, 2'b11, 0, 'h40, 32'h0, 32'h0, 1, 0, 0, 32'h0);
    lit_req(1, 2'b10, 0, 'h41, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 32'h0);
    lit_req(1, 2'b11, 0, 'h40, 32'hFFFFFFFF, 32'h0, 1, 0, 0, 32'h0);
    sweep(1, 'h100, 32'hDEADBEEF);
    sweep(1, 'h40, 32'hABCD3344);

    // Back-to-back stores with req_valid held high
    for (int i = 0; i < 4; i++) begin
      int n, t;
      n = acc_cnt;
      t = 0;
      req_we = 1'b1;
      req_size = (i == 0) ? 2'b10 : ((i == 1) ? 2'b01 : 2'b00);
      req_unsigned = 1'b0;
      req_addr = AW'('h80 + 4 * i + ((i == 1) ? 2 : ((i == 3) ? 3 : 0)));
      req_wdata = 32'hA5000000 + 32'(i);
      req_valid = 1'b1;
      while (acc_cnt == n && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
    end
    req_valid = 1'b0;
    wait_idle();
    sweep(1, 'h8C, 32'h03000000 | (32'(35) * 32'h9E3779B9 & 32'h00FFFFFF));

    // Reset during the MERGE cycle of a byte store
    issue(1, 2'b00, 0, 'h41, 32'h00000055);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_idle();
    sweep(1, 'h40, 32'hABCD3344);

    // Randomized traffic
    for (int it = 0; it < 300; it++) begin
      r = $urandom_range(0, 9);
      sz = (r < 3) ? 2'b00 : ((r < 6) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11));
      a = ($urandom_range(0, 7) == 0) ? AW'('h1FFE0 + $urandom_range(0, 31))
                                       : AW'($urandom_range(0, 'h3FF));
      if ($urandom_range(0, 9) < 7) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 1) == 1) wait_idle();
      issue(1'($urandom), sz, 1'($urandom), a, $urandom);
      if ($urandom_range(0, 15) == 0) begin
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
      end
    end
    wait_idle();
    sweep(0, '0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
